vga_layer_compositor: RTL and testbench
=======================================

# vga_layer_compositor

Parametrised pixel compositor that replaces the hard-wired chain of overlay modules feeding the VGA output. It merges a background colour and `NUM_LAYERS` overlay layers by fixed priority, applies a frame-synchronous global fade (fade-out to black / fade-in to full), and realigns the sync signals to the pixel pipeline. It sits between the per-layer drawing modules and the `hs`/`vs`/`r`/`g`/`b` pins, in the 40 MHz pixel clock domain.

## Interface
- `NUM_LAYERS`, default 6: overlay layer count; must be ≥1. Layer index `NUM_LAYERS-1` is on top.
- `FADE_STEP_FRAMES`, default 4: frames per fade level step; must be ≥1.
- `clk` input 1: pixel clock (40 MHz).
- `rst` input 1: synchronous, active-high reset.
- `vsync_in`, `hsync_in`, `vblnk_in`, `hblnk_in` input 1 each: timing from `vga_timing`, aligned with the pixel data.
- `bg_rgb` input 12: background colour {r,g,b}, 4 bits each.
- `layer_rgb` input 12*NUM_LAYERS: layer k occupies bits [12k+11:12k].
- `layer_valid` input NUM_LAYERS: bit k high means layer k draws an opaque pixel this cycle.
- `layer_en` input NUM_LAYERS: bit k low masks layer k completely.
- `fade_out_req`, `fade_in_req` input 1 each: single-cycle command pulses.
- `hs`, `vs` output 1 each: delayed syncs.
- `rgb` output 12: final colour.
- `fade_level` output 4: current brightness, 0..15.
- `fade_busy` output 1: high while fading.
- `fade_done` output 1: one-cycle pulse when a fade completes.

## Operation
- Stage 1 (registered): winner = highest k with `layer_en[k] & layer_valid[k]`; colour = `layer_rgb[k]`, else `bg_rgb`. Blank = `vblnk_in | hblnk_in`. Syncs and blank are registered alongside.
- Stage 2 (registered): per channel, out = (c * (fade_level+1)) >> 4, using 8-bit intermediate arithmetic. Level 15 passes c unchanged; level 0 gives 0. If the stage-1 blank is set, `rgb` = 0.
- Frame tick: rising edge of `vsync_in`, detected against a registered copy.
- A frame counter 0..FADE_STEP_FRAMES-1 advances on each frame tick while fading and resets on any state change.
- Fade FSM:
  - IDLE (level 15): `fade_out_req` goes to FADE_OUT.
  - FADE_OUT: level decrements by 1 on every tick that wraps the frame counter. When level reaches 0, go to BLACK and pulse `fade_done`.
  - BLACK (level 0): `fade_in_req` goes to FADE_IN.
  - FADE_IN: level increments on wrap. When level reaches 15, go to IDLE and pulse `fade_done`.
- Reversal: `fade_in_req` in FADE_OUT switches to FADE_IN from the current level, and `fade_out_req` in FADE_IN switches to FADE_OUT. In both cases the frame counter clears and no `fade_done` is issued.
- Ignored requests: `fade_out_req` in BLACK or FADE_OUT, and `fade_in_req` in IDLE or FADE_IN.
- Both requests in the same cycle: `fade_out_req` wins.
- `fade_busy` = state is FADE_OUT or FADE_IN.
- `layer_en`/`layer_valid` are sampled every pixel with no per-frame latching.

## Timing
- Pixel latency is exactly 2 cycles from inputs to `rgb`/`hs`/`vs`. Syncs and colour stay mutually aligned.
- Reset values: `hs`=0, `vs`=0, `rgb`=0, all pipeline registers 0, state IDLE, `fade_level`=15, frame counter 0, `fade_busy`=0, `fade_done`=0.
- Reset asserted mid-fade returns to IDLE at level 15 on the next edge with no `fade_done` pulse.
- A level change takes effect on the cycle after the frame tick. A full fade takes 15*FADE_STEP_FRAMES frame ticks.
- `fade_done` asserts in the same cycle that `fade_level` reaches its terminal value.
- A request arriving in the same cycle as a frame tick is processed first; that tick does not step the level.

## Test plan
- Priority: NUM_LAYERS=3, layers 0 and 2 valid and enabled, layer2=12'hF00, layer0=12'h0F0, bg=12'h00F → `rgb`=12'hF00 two cycles later. Clear `layer_en[2]` → 12'h0F0. Clear all valid bits → 12'h00F.
- Blanking/sync alignment: toggle `hblnk_in` and `hsync_in` with constant colour 12'hFFF → `rgb`=0 exactly where the 2-cycle-delayed blank is high, and `hs` equals `hsync_in` delayed by 2 cycles.
- Fade out: FADE_STEP_FRAMES=2, colour 12'hFFF, pulse `fade_out_req`, then 30 vsync rising edges → level steps 15→0 once every 2 frames, `rgb` goes 12'hFFF→12'hEEE→…→12'h000, single `fade_done` pulse, state BLACK.
- Fade in with reversal: from BLACK, `fade_in_req`, then after level 5 pulse `fade_out_req` → level returns down to 0, exactly one `fade_done` (at 0), and `fade_busy` stays high throughout.
- Simultaneous requests plus reset: in IDLE, pulse both requests in the same cycle → FADE_OUT. Assert `rst` at level 9 → next cycle level 15, `fade_busy`=0, `rgb`=0, `hs`=0, `vs`=0.
- Arithmetic: level 7 (fade_level+1 = 8), colour 12'h9A3 → `rgb` = 12'h451.

Source files
------------

// File: rtl/vga_layer_compositor.sv
// Priority layer compositor with frame-synchronous global fade for the VGA output path.
// Two-stage pixel pipeline; syncs travel alongside the colour so they stay aligned.
`timescale 1ns/1ps
module vga_layer_compositor #(
  parameter int NUM_LAYERS       = 6,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_in,
  input  logic                    hsync_in,
  input  logic                    vblnk_in,
  input  logic                    hblnk_in,
  input  logic [11:0]             bg_rgb,
  input  logic [12*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_valid,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic                    fade_out_req,
  input  logic                    fade_in_req,
  output logic                    hs,
  output logic                    vs,
  output logic [11:0]             rgb,
  output logic [3:0]              fade_level,
  output logic                    fade_busy,
  output logic                    fade_done
);

  localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  fade_state_t      state_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             vs_prev_r;
  logic             tick_s;
  logic [11:0]      win_rgb_s;
  logic             blank_s;
  logic [11:0]      rgb1_r;
  logic             blank1_r;
  logic             hs1_r;
  logic             vs1_r;

  // Scale one 4-bit channel by (level+1)/16; level 15 is identity, level 0 is black.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
    return prod[7:4];
  endfunction

  assign tick_s = vsync_in & ~vs_prev_r;

  // Highest-index enabled and valid layer wins; background otherwise.
  always_comb begin
    win_rgb_s = bg_rgb;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      win_rgb_s = (layer_en[k] & layer_valid[k]) ? layer_rgb[12*k +: 12] : win_rgb_s;
    end
    blank_s = vblnk_in | hblnk_in;
  end

  // Stage 1: register the winning colour with blank and syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb1_r   <= 12'd0;
      blank1_r <= 1'b0;
      hs1_r    <= 1'b0;
      vs1_r    <= 1'b0;
    end else begin
      rgb1_r   <= win_rgb_s;
      blank1_r <= blank_s;
      hs1_r    <= hsync_in;
      vs1_r    <= vsync_in;
    end
  end

  // Stage 2: apply the global fade and blanking, delay syncs to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= 12'd0;
      hs  <= 1'b0;
      vs  <= 1'b0;
    end else begin
      hs <= hs1_r;
      vs <= vs1_r;
      if (blank1_r) begin
        rgb <= 12'd0;
      end else begin
        rgb <= {scale_chan(rgb1_r[11:8], fade_level),
                scale_chan(rgb1_r[7:4],  fade_level),
                scale_chan(rgb1_r[3:0],  fade_level)};
      end
    end
  end

  // Fade FSM: state-changing requests take precedence over a coincident frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      fade_level  <= 4'd15;
      frame_cnt_r <= CNT_ZERO;
      fade_busy   <= 1'b0;
      fade_done   <= 1'b0;
      vs_prev_r   <= 1'b0;
    end else begin
      vs_prev_r <= vsync_in;
      fade_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fade_out_req) begin
            state_r     <= FADE_OUT;
            frame_cnt_r <= CNT_ZERO;
            fade_busy   <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (fade_in_req && !fade_out_req) begin
            state_r     <= FADE_IN;
            frame_cnt_r <= CNT_ZERO;
          end else if (tick_s) begin
            if (frame_cnt_r == CNT_LAST) begin
              frame_cnt_r <= CNT_ZERO;
              if (fade_level <= 4'd1) begin
                fade_level <= 4'd0;
                state_r    <= BLACK;
                fade_busy  <= 1'b0;
                fade_done  <= 1'b1;
              end else begin
                fade_level <= fade_level - 4'd1;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end
          end
        end
        BLACK: begin
          if (fade_in_req && !fade_out_req) begin
            state_r     <= FADE_IN;
            frame_cnt_r <= CNT_ZERO;
            fade_busy   <= 1'b1;
          end
        end
        FADE_IN: begin
          if (fade_out_req) begin
            state_r     <= FADE_OUT;
            frame_cnt_r <= CNT_ZERO;
          end else if (tick_s) begin
            if (frame_cnt_r == CNT_LAST) begin
              frame_cnt_r <= CNT_ZERO;
              if (fade_level >= 4'd14) begin
                fade_level <= 4'd15;
                state_r    <= IDLE;
                fade_busy  <= 1'b0;
                fade_done  <= 1'b1;
              end else begin
                fade_level <= fade_level + 4'd1;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          fade_level  <= 4'd15;
          frame_cnt_r <= CNT_ZERO;
          fade_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor: priority, blanking, fades, reversal, reset, arithmetic.
`timescale 1ns/1ps
module tb_vga_layer_compositor;

  localparam int NL = 3;
  localparam int FS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0]   bg_rgb;
  logic [12*NL-1:0] layer_rgb;
  logic [NL-1:0] layer_valid, layer_en;
  logic          fade_out_req, fade_in_req;
  logic          hs, vs;
  logic [11:0]   rgb;
  logic [3:0]    fade_level;
  logic          fade_busy, fade_done;

  vga_layer_compositor #(.NUM_LAYERS(NL), .FADE_STEP_FRAMES(FS)) dut (
    .clk(clk), .rst(rst),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .bg_rgb(bg_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid), .layer_en(layer_en),
    .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .hs(hs), .vs(vs), .rgb(rgb),
    .fade_level(fade_level), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [11:0] col;
    logic [3:0]  lvl;
  } ent_t;

  ent_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference fade model: 0 idle, 1 fade-out, 2 black, 3 fade-in.
  int   m_state = 0;
  int   m_lvl = 15;
  int   m_cnt = 0;
  bit   m_vs_prev = 1'b0;
  bit   m_done = 1'b0;

  function automatic bit m_busy();
    return (m_state == 1) || (m_state == 3);
  endfunction

  function automatic logic [11:0] winner(input logic [11:0] bg, input logic [12*NL-1:0] lr,
                                         input logic [NL-1:0] v, input logic [NL-1:0] en);
    for (int k = NL - 1; k >= 0; k--) begin
      if (v[k] && en[k]) return lr[12*k +: 12];
    end
    return bg;
  endfunction

  function automatic logic [11:0] exp_rgb(input ent_t e);
    int lv, r, g, b;
    if (e.blank) return 12'h000;
    lv = int'(e.lvl) + 1;
    r = (int'(e.col[11:8]) * lv) / 16;
    g = (int'(e.col[7:4])  * lv) / 16;
    b = (int'(e.col[3:0])  * lv) / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic model_step();
    bit tick;
    tick = vsync_in && !m_vs_prev;
    m_vs_prev = vsync_in;
    m_done = 1'b0;
    if (rst) begin
      m_state = 0; m_lvl = 15; m_cnt = 0; m_vs_prev = 1'b0;
    end else begin
      case (m_state)
        0: if (fade_out_req) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (fade_in_req && !fade_out_req) begin m_state = 3; m_cnt = 0; end
          else if (tick) begin
            if (m_cnt == FS - 1) begin
              m_cnt = 0; m_lvl = m_lvl - 1;
              if (m_lvl == 0) begin m_state = 2; m_done = 1'b1; end
            end else m_cnt = m_cnt + 1;
          end
        end
        2: if (fade_in_req && !fade_out_req) begin m_state = 3; m_cnt = 0; end
        default: begin
          if (fade_out_req) begin m_state = 1; m_cnt = 0; end
          else if (tick) begin
            if (m_cnt == FS - 1) begin
              m_cnt = 0; m_lvl = m_lvl + 1;
              if (m_lvl == 15) begin m_state = 0; m_done = 1'b1; end
            end else m_cnt = m_cnt + 1;
          end
        end
      endcase
    end
  endtask

  // One clock: record the expected pixel, advance the model, pop the entry due now.
  task automatic cycle(output bit have, output ent_t e);
    ent_t cur;
    cur = '0;
    cur.hs = hsync_in;
    cur.vs = vsync_in;
    cur.blank = hblnk_in | vblnk_in;
    cur.col = winner(bg_rgb, layer_rgb, layer_valid, layer_en);
    @(posedge clk);
    model_step();
    if (rst) begin
      sb.delete();
      cur = '0;
    end
    cur.lvl = 4'(m_lvl);
    sb.push_back(cur);
    @(negedge clk);
    have = 1'b0;
    e = '0;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit have; ent_t e;
    rst = 1'b1;
    vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
    bg_rgb = 12'hFFF; layer_rgb = '0; layer_valid = '0; layer_en = '1;
    fade_out_req = 1'b0; fade_in_req = 1'b0;
    cycle(have, e);
    cycle(have, e);
    tests_run++;
    if ({hs, vs, rgb} !== {1'b0, 1'b0, 12'h000}) begin
      tests_failed++;
      $display("FAIL reset_pix: got hs=%b vs=%b rgb=%h, want 0 0 000", hs, vs, rgb);
    end
    tests_run++;
    if ({fade_level, fade_busy, fade_done} !== {4'd15, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_fade: got lvl=%0d busy=%b done=%b, want 15 0 0", fade_level, fade_busy, fade_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_priority();
    bit have; ent_t e;
    logic [NL-1:0] val_tab [4] = '{3'b101, 3'b101, 3'b000, 3'b010};
    logic [NL-1:0] en_tab  [4] = '{3'b111, 3'b011, 3'b111, 3'b110};
    logic [11:0]   want_tab[4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h555};
    bg_rgb = 12'h00F;
    layer_rgb = {12'hF00, 12'h555, 12'h0F0};
    for (int i = 0; i < 4; i++) begin
      layer_valid = val_tab[i];
      layer_en = en_tab[i];
      for (int c = 0; c < 3; c++) begin
        cycle(have, e);
        if (have) begin
          tests_run++;
          if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
            tests_failed++;
            $display("FAIL prio_pix: got rgb=%h, want %h", rgb, exp_rgb(e));
          end
        end
      end
      tests_run++;
      if (rgb !== want_tab[i]) begin
        tests_failed++;
        $display("FAIL prio_%0d: got rgb=%h, want %h", i, rgb, want_tab[i]);
      end
    end
  endtask

  task automatic test_blanking();
    bit have; ent_t e;
    bg_rgb = 12'hFFF; layer_valid = '0;
    for (int c = 0; c < 20; c++) begin
      hblnk_in = (c < 16) && (((c >> 1) & 1) == 1);
      hsync_in = (c < 16) && ((c % 3) == 0);
      vblnk_in = (c == 9);
      cycle(have, e);
      if (have) begin
        tests_run++;
        if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
          tests_failed++;
          $display("FAIL blank_pix c=%0d: got hs=%b rgb=%h, want hs=%b rgb=%h", c, hs, rgb, e.hs, exp_rgb(e));
        end
      end
    end
  endtask

  task automatic test_fade_out();
    bit have; ent_t e;
    int done_cnt = 0;
    bg_rgb = 12'hFFF;
    fade_out_req = 1'b1;
    cycle(have, e);
    fade_out_req = 1'b0;
    for (int c = 0; c < 30 * 4 + 6; c++) begin
      vsync_in = (c < 120) && ((c % 4) < 2);
      cycle(have, e);
      if (fade_done === 1'b1) done_cnt++;
      if (have) begin
        tests_run++;
        if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
          tests_failed++;
          $display("FAIL fadeout_pix c=%0d: got rgb=%h vs=%b, want rgb=%h vs=%b", c, rgb, vs, exp_rgb(e), e.vs);
        end
      end
      tests_run++;
      if ({fade_level, fade_busy, fade_done} !== {4'(m_lvl), m_busy(), m_done}) begin
        tests_failed++;
        $display("FAIL fadeout_fsm c=%0d: got lvl=%0d busy=%b done=%b, want %0d %b %b",
                 c, fade_level, fade_busy, fade_done, m_lvl, m_busy(), m_done);
      end
    end
    tests_run++;
    if ({done_cnt == 1, fade_level, fade_busy, rgb} !== {1'b1, 4'd0, 1'b0, 12'h000}) begin
      tests_failed++;
      $display("FAIL fadeout_end: got done_cnt=%0d lvl=%0d busy=%b rgb=%h, want 1 0 0 000",
               done_cnt, fade_level, fade_busy, rgb);
    end
  endtask

  task automatic test_fade_in_reversal();
    bit have; ent_t e;
    int done_cnt = 0;
    int busy_drop = 0;
    int c = 0;
    vsync_in = 1'b0;
    fade_in_req = 1'b1;
    cycle(have, e);
    fade_in_req = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 200; n++) begin
        if (phase == 0 && m_lvl == 5) break;
        if (phase == 1 && m_state == 2) break;
        vsync_in = ((c % 4) < 2);
        c++;
        cycle(have, e);
        if (fade_done === 1'b1) done_cnt++;
        else if (fade_busy !== 1'b1) busy_drop++;
        if (have) begin
          tests_run++;
          if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
            tests_failed++;
            $display("FAIL rev_pix: got rgb=%h, want %h", rgb, exp_rgb(e));
          end
        end
        tests_run++;
        if ({fade_level, fade_busy, fade_done} !== {4'(m_lvl), m_busy(), m_done}) begin
          tests_failed++;
          $display("FAIL rev_fsm: got lvl=%0d busy=%b done=%b, want %0d %b %b",
                   fade_level, fade_busy, fade_done, m_lvl, m_busy(), m_done);
        end
      end
      if (phase == 0) begin
        fade_out_req = 1'b1;
        cycle(have, e);
        fade_out_req = 1'b0;
        if (fade_busy !== 1'b1) busy_drop++;
      end
    end
    tests_run++;
    if ({done_cnt == 1, busy_drop == 0, fade_level} !== {1'b1, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL rev_end: got done_cnt=%0d busy_drop=%0d lvl=%0d, want 1 0 0", done_cnt, busy_drop, fade_level);
    end
  endtask

  task automatic test_simultaneous_reset();
    bit have; ent_t e;
    rst = 1'b1;
    cycle(have, e);
    rst = 1'b0;
    fade_out_req = 1'b1; fade_in_req = 1'b1;
    cycle(have, e);
    fade_out_req = 1'b0; fade_in_req = 1'b0;
    tests_run++;
    if ({fade_busy, fade_level} !== {1'b1, 4'd15}) begin
      tests_failed++;
      $display("FAIL both_req: got busy=%b lvl=%0d, want 1 15", fade_busy, fade_level);
    end
    hsync_in = 1'b1;
    for (int c = 0; c < 200 && m_lvl != 9; c++) begin
      vsync_in = ((c % 4) < 2);
      cycle(have, e);
      if (have) begin
        tests_run++;
        if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
          tests_failed++;
          $display("FAIL sim_pix: got hs=%b vs=%b rgb=%h, want %b %b %h", hs, vs, rgb, e.hs, e.vs, exp_rgb(e));
        end
      end
    end
    tests_run++;
    if (fade_level !== 4'd9) begin
      tests_failed++;
      $display("FAIL sim_lvl9: got lvl=%0d, want 9", fade_level);
    end
    vsync_in = 1'b1;
    rst = 1'b1;
    cycle(have, e);
    rst = 1'b0;
    tests_run++;
    if ({fade_level, fade_busy, fade_done, rgb, hs, vs} !== {4'd15, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got lvl=%0d busy=%b done=%b rgb=%h hs=%b vs=%b, want 15 0 0 000 0 0",
               fade_level, fade_busy, fade_done, rgb, hs, vs);
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cycle(have, e);
    if (have) begin
      tests_run++;
      if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
        tests_failed++;
        $display("FAIL post_reset_pix: got rgb=%h, want %h", rgb, exp_rgb(e));
      end
    end
  endtask

  task automatic test_arithmetic();
    bit have; ent_t e;
    bg_rgb = 12'hFFF;
    fade_out_req = 1'b1;
    cycle(have, e);
    fade_out_req = 1'b0;
    for (int c = 0; c < 200 && m_lvl != 7; c++) begin
      vsync_in = ((c % 4) < 2);
      cycle(have, e);
    end
    vsync_in = 1'b0;
    bg_rgb = 12'h9A3;
    for (int c = 0; c < 3; c++) begin
      cycle(have, e);
      if (have) begin
        tests_run++;
        if ({hs, vs, rgb} !== {e.hs, e.vs, exp_rgb(e)}) begin
          tests_failed++;
          $display("FAIL arith_pix: got rgb=%h, want %h", rgb, exp_rgb(e));
        end
      end
    end
    tests_run++;
    if ({fade_level, rgb} !== {4'd7, 12'h451}) begin
      tests_failed++;
      $display("FAIL arith_lvl7: got lvl=%0d rgb=%h, want 7 451", fade_level, rgb);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_blanking();
    test_fade_out();
    test_fade_in_reversal();
    test_simultaneous_reset();
    test_arithmetic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
